ls_edge_sampler: RTL

Clocked receiver stage directly downstream of the level shifter. It samples the shifter's real-valued output against thresholds proportional to the high-side supply, using hysteresis, and debounces the result into a clean logic level. It emits one-cycle rise/fall pulses, keeps a wrapping edge counter, and holds the output low whenever the high-side supply is below its undervoltage level.

---
 rtl/cds_rnm_pkg.sv | 4 +
 rtl/ls_pkg.sv | 27 ++
 rtl/ls_hyst_classifier.sv | 27 ++
 rtl/ls_edge_sampler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cds_rnm_pkg.sv
// rtl/cds_rnm_pkg.sv - real-number net type used on the analog boundary
package cds_rnm_pkg;
    typedef real wreal1driver;
endpackage

// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared types and default thresholds for the level-shifter sampler
package ls_pkg;
    import cds_rnm_pkg::*;

    typedef wreal1driver ls_volt_t;

    typedef enum logic [2:0] {
        S_UV,
        S_LOW,
        S_PEND_H,
        S_HIGH,
        S_PEND_L
    } ls_state_e;

    typedef enum logic [1:0] {
        CLS_LO,
        CLS_MID,
        CLS_HI,
        CLS_UV
    } ls_class_e;

    localparam real LS_VTH_HI_FRAC_DEF = 0.7;
    localparam real LS_VTH_LO_FRAC_DEF = 0.3;
    localparam real LS_UV_LEVEL_DEF    = 1.0;
    localparam int  LS_DEBOUNCE_DEF    = 4;
    localparam int  LS_CNT_W_DEF       = 16;
endpackage

// File: rtl/ls_hyst_classifier.sv
// rtl/ls_hyst_classifier.sv - maps VIN against supply-relative thresholds to a sample class
module ls_hyst_classifier
    import ls_pkg::*;
(
    input  ls_volt_t  vin,
    input  ls_volt_t  vcc_high,
    input  ls_volt_t  vth_hi_frac,
    input  ls_volt_t  vth_lo_frac,
    input  ls_volt_t  uv_level,
    output ls_class_e cls
);

    always_comb begin
        cls = CLS_MID;
        if (vcc_high < uv_level) begin
            cls = CLS_UV;
        end else if (vin != vin) begin
            // an undriven or contended real net arrives as NaN; treat it as indeterminate
            cls = CLS_MID;
        end else if (vin > vcc_high * vth_hi_frac) begin
            cls = CLS_HI;
        end else if (vin < vcc_high * vth_lo_frac) begin
            cls = CLS_LO;
        end
    end

endmodule

// File: rtl/ls_edge_sampler.sv
// rtl/ls_edge_sampler.sv - hysteresis sampler and debouncer with edge pulses, edge counter
// and undervoltage hold-off
module ls_edge_sampler
    import ls_pkg::*;
#(
    parameter real VTH_HI_FRAC = LS_VTH_HI_FRAC_DEF,
    parameter real VTH_LO_FRAC = LS_VTH_LO_FRAC_DEF,
    parameter int  DEBOUNCE    = LS_DEBOUNCE_DEF,
    parameter real UV_LEVEL    = LS_UV_LEVEL_DEF,
    parameter int  CNT_W       = LS_CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  ls_volt_t         VIN,
    input  ls_volt_t         VCC_HIGH,
    input  logic             CLR,
    output logic             DOUT,
    output logic             RISE,
    output logic             FALL,
    output logic [CNT_W-1:0] EDGE_CNT,
    output logic             UV_FLAG
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

    ls_class_e        cls;
    ls_state_e        state_q, state_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic             rise_d, fall_d, dout_d, uv_flag_d, edge_ev;
    logic [CNT_W-1:0] cnt_d;

    ls_hyst_classifier u_classifier (
        .vin         (VIN),
        .vcc_high    (VCC_HIGH),
        .vth_hi_frac (VTH_HI_FRAC),
        .vth_lo_frac (VTH_LO_FRAC),
        .uv_level    (UV_LEVEL),
        .cls         (cls)
    );

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (cls == CLS_UV) begin
            state_d = S_UV;
            db_d    = '0;
        end else begin
            case (state_q)
                S_UV: begin
                    state_d = S_LOW;
                    db_d    = '0;
                end
                S_LOW: begin
                    if (cls == CLS_HI) begin
                        if (DEBOUNCE == 1) begin
                            state_d = S_HIGH;
                            rise_d  = 1'b1;
                            db_d    = '0;
                        end else begin
                            state_d = S_PEND_H;
                            db_d    = DB_W'(1);
                        end
                    end
                end
                S_PEND_H: begin
                    case (cls)
                        CLS_HI: begin
                            if (db_q + 1'b1 == DB_MAX) begin
                                state_d = S_HIGH;
                                rise_d  = 1'b1;
                                db_d    = '0;
                            end else begin
                                db_d = db_q + 1'b1;
                            end
                        end
                        CLS_LO: begin
                            state_d = S_LOW;
                            db_d    = '0;
                        end
                        default: ;
                    endcase
                end
                S_HIGH: begin
                    if (cls == CLS_LO) begin
                        if (DEBOUNCE == 1) begin
                            state_d = S_LOW;
                            fall_d  = 1'b1;
                            db_d    = '0;
                        end else begin
                            state_d = S_PEND_L;
                            db_d    = DB_W'(1);
                        end
                    end
                end
                S_PEND_L: begin
                    case (cls)
                        CLS_LO: begin
                            if (db_q + 1'b1 == DB_MAX) begin
                                state_d = S_LOW;
                                fall_d  = 1'b1;
                                db_d    = '0;
                            end else begin
                                db_d = db_q + 1'b1;
                            end
                        end
                        CLS_HI: begin
                            state_d = S_HIGH;
                            db_d    = '0;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state_d = S_UV;
                    db_d    = '0;
                end
            endcase
        end

        // a pending fall still reads as high: DOUT only moves on a completed debounce
        dout_d    = (state_d == S_HIGH) || (state_d == S_PEND_L);
        uv_flag_d = (state_d == S_UV);
        edge_ev   = rise_d | fall_d;
        cnt_d     = CLR ? CNT_W'(edge_ev) : EDGE_CNT + CNT_W'(edge_ev);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_UV;
            db_q     <= '0;
            DOUT     <= 1'b0;
            RISE     <= 1'b0;
            FALL     <= 1'b0;
            EDGE_CNT <= '0;
            UV_FLAG  <= 1'b1;
        end else begin
            state_q  <= state_d;
            db_q     <= db_d;
            DOUT     <= dout_d;
            RISE     <= rise_d;
            FALL     <= fall_d;
            EDGE_CNT <= cnt_d;
            UV_FLAG  <= uv_flag_d;
        end
    end

endmodule
